// File: rtl/axi_rd_ctrl.sv
// AXI4 read master: splits a beat-count command into INCR bursts and streams the data out.
// Define AXI_RD_4K_SPLIT_EN to keep every burst inside one 4 KB page.
module axi_rd_ctrl #(
    parameter int unsigned DATA_WIDTH    = 512,
    parameter int unsigned KEEP_WIDTH    = DATA_WIDTH / 8,
    parameter int unsigned ADDR_WIDTH    = 34,
    parameter int unsigned LEN_WIDTH     = 16,
    parameter int unsigned MAX_BURST_LEN = 16
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [LEN_WIDTH-1:0]  cmd_len,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,

    output logic                  status_busy,
    output logic                  status_error,

    output logic [5:0]            m_axi_arid,
    output logic [ADDR_WIDTH-1:0] m_axi_araddr,
    output logic [7:0]            m_axi_arlen,
    output logic [2:0]            m_axi_arsize,
    output logic [1:0]            m_axi_arburst,
    output logic                  m_axi_arlock,
    output logic [3:0]            m_axi_arcache,
    output logic [2:0]            m_axi_arprot,
    output logic                  m_axi_arvalid,
    input  logic                  m_axi_arready,

    input  logic [5:0]            m_axi_rid,
    input  logic [DATA_WIDTH-1:0] m_axi_rdata,
    input  logic [1:0]            m_axi_rresp,
    input  logic                  m_axi_rlast,
    input  logic                  m_axi_rvalid,
    output logic                  m_axi_rready,

    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic [KEEP_WIDTH-1:0] m_axis_tkeep,
    output logic                  m_axis_tlast,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready
);

    localparam int unsigned OffsBits  = $clog2(KEEP_WIDTH);
    localparam int unsigned CntW      = (LEN_WIDTH > 13) ? LEN_WIDTH : 13;
`ifdef AXI_RD_4K_SPLIT_EN
    localparam int unsigned PageBeats = 4096 / KEEP_WIDTH;
`endif

    typedef enum logic [1:0] {StIdle, StAddr, StData} state_e;

    state_e                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [LEN_WIDTH-1:0]    rem_q, rem_d;
    logic [8:0]              burst_q, burst_d;
    logic [8:0]              beat_q, beat_d;
    logic                    err_q, err_d;
    logic                    wr_ptr_q, wr_ptr_d;
    logic                    rd_ptr_q, rd_ptr_d;
    logic [1:0]              cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0]   buf_data_q [2];
    logic                    buf_last_q [2];

    logic [CntW-1:0]         beats;
    logic                    push, pop, last_beat, push_last;
    logic                    unused_rid;

    assign unused_rid = ^m_axi_rid;

    // Beats in the next burst, derived from the registered address and remaining count.
    always_comb begin
        beats = (CntW'(rem_q) < CntW'(MAX_BURST_LEN)) ? CntW'(rem_q) : CntW'(MAX_BURST_LEN);
`ifdef AXI_RD_4K_SPLIT_EN
        if ((CntW'(PageBeats) - CntW'(addr_q[11:OffsBits])) < beats) begin
            beats = CntW'(PageBeats) - CntW'(addr_q[11:OffsBits]);
        end
`endif
    end

    assign cmd_ready     = (state_q == StIdle);
    assign status_busy   = (state_q != StIdle) || (cnt_q != 2'd0);
    assign status_error  = err_q;

    assign m_axi_arid    = 6'd0;
    assign m_axi_araddr  = addr_q;
    assign m_axi_arlen   = 8'(beats - CntW'(1));
    assign m_axi_arsize  = 3'(OffsBits);
    assign m_axi_arburst = 2'd1;
    assign m_axi_arlock  = 1'b0;
    assign m_axi_arcache = 4'd0;
    assign m_axi_arprot  = 3'd0;
    assign m_axi_arvalid = (state_q == StAddr);
    assign m_axi_rready  = (state_q == StData) && (cnt_q != 2'd2);

    assign m_axis_tvalid = (cnt_q != 2'd0);
    assign m_axis_tdata  = buf_data_q[rd_ptr_q];
    assign m_axis_tlast  = m_axis_tvalid && buf_last_q[rd_ptr_q];
    assign m_axis_tkeep  = '1;

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        rem_d     = rem_q;
        burst_d   = burst_q;
        beat_d    = beat_q;
        err_d     = err_q;
        push      = m_axi_rvalid && m_axi_rready;
        pop       = m_axis_tvalid && m_axis_tready;
        last_beat = (beat_q == burst_q - 9'd1);
        // rem_q already excludes the current burst, so zero means this is the command's tail.
        push_last = last_beat && (rem_q == '0);
        wr_ptr_d  = wr_ptr_q ^ push;
        rd_ptr_d  = rd_ptr_q ^ pop;
        cnt_d     = cnt_q + 2'(push) - 2'(pop);

        unique case (state_q)
            StIdle: begin
                if (cmd_valid) begin
                    err_d  = 1'b0;
                    addr_d = cmd_addr & ~ADDR_WIDTH'(KEEP_WIDTH - 1);
                    rem_d  = cmd_len;
                    if (cmd_len != '0) begin
                        state_d = StAddr;
                    end
                end
            end
            StAddr: begin
                if (m_axi_arready) begin
                    addr_d  = addr_q + (ADDR_WIDTH'(beats) << OffsBits);
                    rem_d   = rem_q - LEN_WIDTH'(beats);
                    burst_d = 9'(beats);
                    beat_d  = 9'd0;
                    state_d = StData;
                end
            end
            StData: begin
                if (push) begin
                    beat_d = beat_q + 9'd1;
                    if ((m_axi_rresp != 2'd0) || (m_axi_rlast != last_beat)) begin
                        err_d = 1'b1;
                    end
                    if (last_beat) begin
                        state_d = (rem_q != '0) ? StAddr : StIdle;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= StIdle;
            addr_q   <= '0;
            rem_q    <= '0;
            burst_q  <= '0;
            beat_q   <= '0;
            err_q    <= 1'b0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            rem_q    <= rem_d;
            burst_q  <= burst_d;
            beat_q   <= beat_d;
            err_q    <= err_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    // Payload storage needs no reset; occupancy is tracked by cnt_q.
    always_ff @(posedge clk) begin
        if (push) begin
            buf_data_q[wr_ptr_q] <= m_axi_rdata;
            buf_last_q[wr_ptr_q] <= push_last;
        end
    end

endmodule

// File: tb/tb_axi_rd_ctrl.sv
// Randomized bench for axi_rd_ctrl: AXI slave and stream sink models plus an address-level
// reference model of the expected bursts and stream contents.
`timescale 1ns/1ps
module tb_axi_rd_ctrl;

    localparam int unsigned DW  = 512;
    localparam int unsigned KW  = DW / 8;
    localparam int unsigned AW  = 34;
    localparam int unsigned LW  = 16;
    localparam int unsigned MBL = 16;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [7:0]    len;
    } burst_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [AW-1:0] cmd_addr = '0;
    logic [LW-1:0] cmd_len = '0;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready, status_busy, status_error;
    logic [5:0]    arid;
    logic [AW-1:0] araddr;
    logic [7:0]    arlen;
    logic [2:0]    arsize;
    logic [1:0]    arburst;
    logic          arlock;
    logic [3:0]    arcache;
    logic [2:0]    arprot;
    logic          arvalid, arready;
    logic [5:0]    rid;
    logic [DW-1:0] rdata;
    logic [1:0]    rresp;
    logic          rlast, rvalid, rready;
    logic [DW-1:0] tdata;
    logic [KW-1:0] tkeep;
    logic          tlast, tvalid, tready;

    int n_tests = 0;
    int n_fails = 0;

    burst_t       r_pend[$];
    burst_t       ar_log[$];
    burst_t       exp_ar[$];
    logic [DW:0]  got_q[$];
    int           slave_mode = 0;
    int           tready_mode = 0;
    int           err_idx = -1;
    int           cmd_rbeat = 0;
    int           outstanding = 0;
    bit           saw_r_block = 1'b0;

    axi_rd_ctrl #(
        .DATA_WIDTH(DW), .KEEP_WIDTH(KW), .ADDR_WIDTH(AW), .LEN_WIDTH(LW), .MAX_BURST_LEN(MBL)
    ) dut (
        .clk(clk), .rst(rst),
        .cmd_addr(cmd_addr), .cmd_len(cmd_len), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .status_busy(status_busy), .status_error(status_error),
        .m_axi_arid(arid), .m_axi_araddr(araddr), .m_axi_arlen(arlen), .m_axi_arsize(arsize),
        .m_axi_arburst(arburst), .m_axi_arlock(arlock), .m_axi_arcache(arcache),
        .m_axi_arprot(arprot), .m_axi_arvalid(arvalid), .m_axi_arready(arready),
        .m_axi_rid(rid), .m_axi_rdata(rdata), .m_axi_rresp(rresp), .m_axi_rlast(rlast),
        .m_axi_rvalid(rvalid), .m_axi_rready(rready),
        .m_axis_tdata(tdata), .m_axis_tkeep(tkeep), .m_axis_tlast(tlast),
        .m_axis_tvalid(tvalid), .m_axis_tready(tready)
    );

    initial forever #5 clk = ~clk;

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [DW:0] got, input logic [DW:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Memory contents are a fixed function of the byte address, so data order is checkable.
    function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
        logic [DW-1:0] w;
        for (int i = 0; i < DW / 32; i++) begin
            w[i*32 +: 32] = 32'(a >> 2) ^ (32'(i + 1) * 32'h9E37_79B9);
        end
        return w;
    endfunction

    // AXI slave and stream sink; a handshake is recorded when valid&ready is set up at negedge.
    initial begin
        burst_t        cur, b;
        int            r_beat = 0;
        bit            r_active = 1'b0, r_fire = 1'b0, ar_stall = 1'b0, t_stall = 1'b0;
        logic [AW-1:0] st_addr = '0;
        logic [7:0]    st_len = '0;
        logic [DW-1:0] st_data = '0;
        logic          st_last = 1'b0;
        cur = '0;
        arready = 1'b0; rvalid = 1'b0; rdata = '0; rresp = 2'd0; rlast = 1'b0; rid = 6'd0;
        tready = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                arready = 1'b0; rvalid = 1'b0; rlast = 1'b0; tready = 1'b0;
                r_pend.delete(); r_active = 1'b0; r_fire = 1'b0;
                ar_stall = 1'b0; t_stall = 1'b0; outstanding = 0;
            end else begin
                if (r_fire) begin
                    r_beat++;
                    if (r_beat > int'(cur.len)) r_active = 1'b0;
                end
                if (!r_active && r_pend.size() > 0) begin
                    cur = r_pend.pop_front();
                    r_active = 1'b1;
                    r_beat = 0;
                end
                if (r_active && (slave_mode == 1 || $urandom_range(0, 3) != 0)) begin
                    rvalid = 1'b1;
                    rdata  = mem_word(cur.addr + AW'(r_beat * KW));
                    rlast  = (r_beat == int'(cur.len));
                    rresp  = (cmd_rbeat == err_idx) ? 2'd2 : 2'd0;
                    rid    = 6'($urandom);
                end else begin
                    rvalid = 1'b0; rlast = 1'b0; rresp = 2'd0;
                end
                r_fire = rvalid && rready;
                if (rvalid && !rready) saw_r_block = 1'b1;
                if (r_fire) begin
                    cmd_rbeat++;
                    outstanding--;
                end

                arready = (slave_mode == 1) || ($urandom_range(0, 2) != 0);
                if (arvalid) begin
                    if (ar_stall) begin
                        check_eq("ar_addr_stable", araddr, st_addr);
                        check_eq("ar_len_stable", arlen, st_len);
                    end
                    if (arready) begin
                        check_eq("ar_one_outstanding", outstanding, 0);
                        b.addr = araddr;
                        b.len  = arlen;
                        ar_log.push_back(b);
                        r_pend.push_back(b);
                        outstanding += int'(arlen) + 1;
                        ar_stall = 1'b0;
                    end else begin
                        ar_stall = 1'b1; st_addr = araddr; st_len = arlen;
                    end
                end else begin
                    ar_stall = 1'b0;
                end

                case (tready_mode)
                    1:       tready = 1'b1;
                    2:       tready = !tready;
                    default: tready = 1'($urandom_range(0, 1));
                endcase
                if (tvalid) begin
                    if (t_stall) begin
                        check_eq("t_data_stable", tdata, st_data);
                        check_eq("t_last_stable", tlast, st_last);
                    end
                    if (tready) begin
                        got_q.push_back({tlast, tdata});
                        t_stall = 1'b0;
                    end else begin
                        t_stall = 1'b1; st_data = tdata; st_last = tlast;
                    end
                end else begin
                    t_stall = 1'b0;
                end
            end
        end
    end

    task automatic send_cmd(input logic [AW-1:0] a, input int len, input int err);
        int cyc = 0;
        ar_log.delete();
        got_q.delete();
        err_idx = err;
        cmd_rbeat = 0;
        @(negedge clk);
        while (!cmd_ready && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        check_eq("cmd_ready_wait", cmd_ready, 1'b1);
        cmd_addr = a; cmd_len = LW'(len); cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        check_eq("arvalid_next", arvalid, len > 0);
        check_eq("err_cleared", status_error, 1'b0);
    endtask

    task automatic run_cmd(input logic [AW-1:0] a, input int len, input int err);
        burst_t        e;
        logic [AW-1:0] base, x;
        int            rem, b, cyc, n;
        base = a & ~AW'(KW - 1);
        x = base;
        rem = len;
        exp_ar.delete();
        while (rem > 0) begin
            b = (rem < MBL) ? rem : MBL;
`ifdef AXI_RD_4K_SPLIT_EN
            if ((4096 - int'(x % 4096)) / KW < b) b = (4096 - int'(x % 4096)) / KW;
`endif
            e.addr = x;
            e.len  = 8'(b - 1);
            exp_ar.push_back(e);
            x = x + AW'(b * KW);
            rem -= b;
        end
        send_cmd(a, len, err);
        cyc = 0;
        while ((status_busy || got_q.size() < len) && cyc < 20000) begin
            @(negedge clk);
            cyc++;
        end
        check_eq("done_in_time", cyc < 20000, 1'b1);
        check_eq("status_error", status_error, (err >= 0) && (err < len));
        check_eq("ar_count", ar_log.size(), exp_ar.size());
        n = (ar_log.size() < exp_ar.size()) ? ar_log.size() : exp_ar.size();
        for (int i = 0; i < n; i++) begin
            check_eq("ar_addr", ar_log[i].addr, exp_ar[i].addr);
            check_eq("ar_len", ar_log[i].len, exp_ar[i].len);
        end
        check_eq("beat_count", got_q.size(), len);
        n = (got_q.size() < len) ? got_q.size() : len;
        for (int k = 0; k < n; k++) begin
            check_eq("beat_data", got_q[k][DW-1:0], mem_word(base + AW'(k * KW)));
            check_eq("beat_last", got_q[k][DW], k == len - 1);
        end
    endtask

    initial begin
        int cyc;
        int len;
        int err;
        logic [AW-1:0] a;

        repeat (3) @(negedge clk);
        check_eq("rst_arvalid", arvalid, 1'b0);
        check_eq("rst_rready", rready, 1'b0);
        check_eq("rst_tvalid", tvalid, 1'b0);
        check_eq("rst_tlast", tlast, 1'b0);
        check_eq("rst_busy", status_busy, 1'b0);
        check_eq("rst_error", status_error, 1'b0);
        rst = 1'b0;
        @(negedge clk);
        check_eq("rst_cmd_ready", cmd_ready, 1'b1);
        check_eq("ar_consts", {arid, arsize, arburst, arlock, arcache, arprot},
                 {6'd0, 3'd6, 2'd1, 1'b0, 4'd0, 3'd0});
        check_eq("tkeep_ones", tkeep, {KW{1'b1}});

        slave_mode = 1; tready_mode = 1;
        run_cmd(34'h0, 3, -1);
        run_cmd(34'h0, 40, -1);
        run_cmd(34'hF80, 4, -1);
        run_cmd(34'h3_FFFF_FF80, 5, -1);

        tready_mode = 2; saw_r_block = 1'b0;
        run_cmd(34'h2000, 8, -1);
        check_eq("rready_drop_when_full", saw_r_block, 1'b1);

        tready_mode = 1;
        run_cmd(34'h4000, 4, 1);
        run_cmd(34'h5000, 2, -1);

        run_cmd(34'h6000, 0, -1);
        check_eq("len0_idle", cmd_ready, 1'b1);

        for (int t = 0; t < 25; t++) begin
            slave_mode  = int'($urandom_range(0, 1));
            tready_mode = int'($urandom_range(0, 2));
            a = AW'({$urandom, $urandom});
            if ($urandom_range(0, 2) == 0) a[11:0] = 12'hE00 | 12'($urandom_range(0, 511));
            len = int'($urandom_range(1, 70));
            err = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, len - 1)) : -1;
            run_cmd(a, len, err);
        end

        // Reset in the middle of a data phase.
        slave_mode = 1; tready_mode = 0;
        send_cmd(34'h8000, 16, -1);
        cyc = 0;
        while (cmd_rbeat < 3 && cyc < 1000) begin
            @(negedge clk);
            cyc++;
        end
        check_eq("reached_data", cyc < 1000, 1'b1);
        rst = 1'b1;
        #1;
        check_eq("midrst_arvalid", arvalid, 1'b0);
        check_eq("midrst_rready", rready, 1'b0);
        check_eq("midrst_tvalid", tvalid, 1'b0);
        check_eq("midrst_busy", status_busy, 1'b0);
        repeat (3) @(negedge clk);
        got_q.delete();
        rst = 1'b0;
        @(negedge clk);
        check_eq("midrst_cmd_ready", cmd_ready, 1'b1);
        repeat (30) @(negedge clk);
        check_eq("midrst_no_beats", got_q.size(), 0);
        check_eq("midrst_idle", status_busy, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fails);
        $finish;
    end

endmodule

// File: doc/axi_rd_ctrl.md
AXI_RD_CTRL -- requirements
Module: axi_rd_ctrl

Interface
REQ-001 Parameters (name, default, meaning), one per line:
 DATA_WIDTH, 512, AXI read data and stream width (bits).
 KEEP_WIDTH, DATA_WIDTH/8, stream tkeep width (bytes per beat).
 ADDR_WIDTH, 34, AXI address width.
 LEN_WIDTH, 16, command length width (beats).
 MAX_BURST_LEN, 16, maximum beats per AXI burst (1..256).
REQ-002 Clocking and reset: one clock, clk; reset rst is asynchronous and active-high.
REQ-003 Ports (name, direction, width, meaning), one per line:
 clk  in  1  clock.
 rst  in  1  asynchronous active-high reset.
 cmd_addr  in  ADDR_WIDTH  byte start address; low log2(KEEP_WIDTH) bits ignored and treated as zero.
 cmd_len  in  LEN_WIDTH  number of beats to read.
 cmd_valid / cmd_ready  in / out  1  command handshake.
 status_busy  out  1  command in progress or stream data pending.
 status_error  out  1  sticky error flag; cleared by the next accepted command.
 m_axi_arid  out  6  constant 0.
 m_axi_araddr  out  ADDR_WIDTH  burst address.
 m_axi_arlen  out  8  beats-1.
 m_axi_arsize  out  3  log2(KEEP_WIDTH).
 m_axi_arburst  out  2  INCR (1).
 m_axi_arlock / arcache / arprot  out  1/4/3  all zero.
 m_axi_arvalid / m_axi_arready  out / in  1  AR handshake.
 m_axi_rid  in  6  ignored.
 m_axi_rdata  in  DATA_WIDTH  read data.
 m_axi_rresp  in  2  read response.
 m_axi_rlast  in  1  last beat of burst.
 m_axi_rvalid / m_axi_rready  in / out  1  R handshake.
 m_axis_tdata  out  DATA_WIDTH  stream data.
 m_axis_tkeep  out  KEEP_WIDTH  all ones.
 m_axis_tlast  out  1  final beat of command.
 m_axis_tvalid / m_axis_tready  out / in  1  stream handshake.

Function
REQ-004 The state machine SHALL have states IDLE, ADDR and DATA; cmd_ready=1 only in IDLE.
REQ-005 On a command handshake with cmd_len>0: latch address and length, clear status_error, enter ADDR; m_axi_arvalid rises the next cycle.
REQ-006 A command with cmd_len=0 SHALL be accepted, generate no AXI or stream traffic, and leave the block in IDLE.
REQ-007 Burst beats = min(remaining, MAX_BURST_LEN, beats to the next 4 KB boundary when the split feature is enabled); arlen = beats-1.
REQ-008 In ADDR, arvalid, araddr and arlen SHALL stay stable until arready; the AR handshake moves to DATA and advances the address by beats*KEEP_WIDTH.
REQ-009 Only one burst SHALL be outstanding; the next AR is issued only after the last R beat of the current burst.
REQ-010 m_axi_rready = 1 when the 2-entry output skid buffer has a free entry; rdata reaches m_axis_tvalid one cycle after the R handshake.
REQ-011 After the expected beat count of a burst: go to ADDR if beats remain, otherwise go to IDLE.
REQ-012 status_error SHALL set if rresp != 0 on any beat, or if rlast does not match the expected last beat; transfer continues by internal count.
REQ-013 m_axis_tlast = 1 only on the beat carrying the final beat of the command.
REQ-014 m_axis data SHALL stay stable while tvalid=1 and tready=0; no beat dropped or duplicated.
REQ-015 status_busy = (state != IDLE) OR (skid buffer not empty).
REQ-016 Remaining-beat and address arithmetic SHALL be unsigned; address wraps modulo 2^ADDR_WIDTH.

Reset
REQ-017 On rst: state IDLE; cmd_ready=1 after release; arvalid, rready, m_axis_tvalid, m_axis_tlast, status_busy and status_error all 0; skid buffer empty.
REQ-018 A reset asserted mid-transfer SHALL abandon the command immediately; no stream beats are emitted after the reset.

Configuration
REQ-019 With macro AXI_RD_4K_SPLIT_EN defined, no burst SHALL cross a 4 KB address boundary; without it, burst size is limited only by remaining length and MAX_BURST_LEN.

Verification
REQ-020 addr 0x0, len 3, arready/tready always 1 -> one AR (araddr 0x0, arlen 2); 3 stream beats; tlast on beat 3; busy then falls.
REQ-021 addr 0x0, len 40, MAX_BURST_LEN 16 -> ARs at 0x0, 0x400, 0x800 with arlen 15, 15, 7; 40 stream beats in order.
REQ-022 AXI_RD_4K_SPLIT_EN defined, addr 0xF80, len 4 -> AR 0xF80 arlen 1, then AR 0x1000 arlen 1; undefined -> single AR 0xF80 arlen 3.
REQ-023 tready toggled 1/0 each cycle during len 8 -> rready drops when the skid buffer is full; all 8 beats delivered intact and stable while stalled.
REQ-024 rresp=2 on beat 2 of a len-4 command -> status_error=1, 4 beats still emitted; next accepted command clears status_error.
REQ-025 rst asserted during DATA of a len-16 command -> arvalid, rready and tvalid are 0 immediately; cmd_ready=1 after release.
